// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port data RAM between the CPU MEM stage and a debug/display read port.
// Ports:
//   clk, rst (async, active-low)
//   cpu_req/cpu_rw/cpu_addr/cpu_sel/cpu_wdata -> cpu_rdata, cpu_stall : CPU access port
//   dbg_req/dbg_addr -> dbg_gnt, dbg_rdata, dbg_valid                 : debug read port
//   ram_addr/ram_data_in/ram_sel/ram_rw, ram_data_out                  : RAM port (async read)
//   dbg_grant_num, stall_num                                           : wrapping event counters
module ram_arbiter #(
    parameter int ADDR_BITS = 12,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_rw,
    input  logic [ADDR_BITS-3:0] cpu_addr,
    input  logic [3:0]           cpu_sel,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_stall,
    input  logic                 dbg_req,
    input  logic [ADDR_BITS-3:0] dbg_addr,
    output logic                 dbg_gnt,
    output logic [31:0]          dbg_rdata,
    output logic                 dbg_valid,
    output logic [ADDR_BITS-3:0] ram_addr,
    output logic [31:0]          ram_data_in,
    output logic [3:0]           ram_sel,
    output logic                 ram_rw,
    input  logic [31:0]          ram_data_out,
    output logic [31:0]          dbg_grant_num,
    output logic [31:0]          stall_num
);
    typedef enum logic {S_CPU, S_DBG} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_nxt;

    assign cpu_rdata = ram_data_out;

    always_comb begin
        state_nxt   = state;
        wait_nxt    = '0;
        ram_addr    = cpu_addr;
        ram_sel     = cpu_sel;
        ram_data_in = cpu_wdata;
        ram_rw      = cpu_req & cpu_rw;
        dbg_gnt     = 1'b0;
        cpu_stall   = 1'b0;
        if (state == S_CPU) begin
            // Debug wins on an idle CPU cycle, or once the CPU has won MAX_WAIT contested cycles.
            if (dbg_req && (!cpu_req || wait_cnt == WAIT_LAST))
                state_nxt = S_DBG;
            else if (dbg_req && cpu_req)
                wait_nxt = wait_cnt + 4'd1;
        end else begin
            // One debug word per grant; always hand the RAM back for at least a cycle.
            state_nxt   = S_CPU;
            ram_addr    = dbg_addr;
            ram_sel     = 4'b1111;
            ram_data_in = '0;
            ram_rw      = 1'b0;
            dbg_gnt     = 1'b1;
            cpu_stall   = cpu_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_CPU;
            wait_cnt      <= '0;
            dbg_rdata     <= '0;
            dbg_valid     <= 1'b0;
            dbg_grant_num <= '0;
            stall_num     <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            dbg_valid <= dbg_gnt;
            if (dbg_gnt) begin
                dbg_rdata     <= ram_data_out;
                dbg_grant_num <= dbg_grant_num + 32'd1;
            end
            if (cpu_stall)
                stall_num <= stall_num + 32'd1;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed, scoreboard-based bench for ram_arbiter with a behavioural async-read RAM.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_rw;
    logic [9:0]  cpu_addr;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic [9:0]  dbg_addr;
    logic        dbg_gnt, dbg_valid;
    logic [31:0] dbg_rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data_in, ram_data_out;
    logic [3:0]  ram_sel;
    logic        ram_rw;
    logic [31:0] dbg_grant_num, stall_num;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_BITS(12), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_sel(ram_sel), .ram_rw(ram_rw),
        .ram_data_out(ram_data_out), .dbg_grant_num(dbg_grant_num), .stall_num(stall_num)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    assign ram_data_out = mem[ram_addr];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (ram_rw) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every dbg_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dbg_valid) begin
            if (exp_q.size() == 0) chk("unexpected_dbg_valid", 32'd1, 32'd0);
            else chk("sb_dbg_rdata", dbg_rdata, exp_q.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        rst = 1'b0; cpu_req = 0; cpu_rw = 0; cpu_addr = '0; cpu_sel = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_addr = '0;
        #2;
        chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_dbg_valid", {31'd0, dbg_valid}, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        chk("rst_grant_num", dbg_grant_num, 32'd0);
        chk("rst_stall_num", stall_num, 32'd0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();

        // Idle CPU: debug read of address 5 is granted next cycle.
        dbg_req = 1; dbg_addr = 10'd5; exp_q.push_back(ref_mem[5]);
        #1 chk("t37_no_gnt_yet", {31'd0, dbg_gnt}, 32'd0);
        cyc();
        dbg_req = 0;
        #1 chk("t37_gnt", {31'd0, dbg_gnt}, 32'd1);
        chk("t37_ram_addr", {22'd0, ram_addr}, 32'd5);
        chk("t37_ram_sel", {28'd0, ram_sel}, 32'hF);
        chk("t37_ram_rw", {31'd0, ram_rw}, 32'd0);
        cyc();
        #1 chk("t37_valid", {31'd0, dbg_valid}, 32'd1);
        chk("t37_rdata", dbg_rdata, 32'hDEADBEEF);
        chk("t37_grant_num", dbg_grant_num, 32'd1);
        chk("t37_gnt_off", {31'd0, dbg_gnt}, 32'd0);
        cyc();
        chk("t37_valid_once", {31'd0, dbg_valid}, 32'd0);

        // CPU write with debug idle, then read it back.
        cpu_req = 1; cpu_rw = 1; cpu_addr = 10'd3; cpu_wdata = 32'h12345678; cpu_sel = 4'b1111;
        ref_mem[3] = 32'h12345678;
        #1 chk("t39_ram_rw", {31'd0, ram_rw}, 32'd1);
        chk("t39_stall", {31'd0, cpu_stall}, 32'd0);
        chk("t39_ram_addr", {22'd0, ram_addr}, 32'd3);
        chk("t39_ram_data", ram_data_in, 32'h12345678);
        cyc();
        cpu_rw = 0;
        #1 chk("t39_mem3", mem[3], 32'h12345678);
        chk("t39_rdata", cpu_rdata, 32'h12345678);
        chk("t39_read_rw", {31'd0, ram_rw}, 32'd0);
        cyc();

        // Continuous CPU traffic: debug forced in on cycle 4.
        cpu_addr = 10'd20; dbg_req = 1; dbg_addr = 10'd7; exp_q.push_back(ref_mem[7]);
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("t38_gnt_c%0d", c), {31'd0, dbg_gnt}, {31'd0, c == 4});
            chk($sformatf("t38_stall_c%0d", c), {31'd0, cpu_stall}, {31'd0, c == 4});
            if (c != 4) chk($sformatf("t38_rdata_c%0d", c), cpu_rdata, ref_mem[20]);
            if (c == 4) dbg_req = 0;
            cyc();
        end
        chk("t38_stall_num", stall_num, 32'd1);
        chk("t38_grant_num", dbg_grant_num, 32'd2);

        // Debug request withdrawn under contention: no grant, counters unchanged.
        dbg_addr = 10'd11;
        for (int c = 0; c < 6; c++) begin
            dbg_req = (c < 2);
            #1 chk($sformatf("t40_no_gnt_c%0d", c), {31'd0, dbg_gnt}, 32'd0);
            cyc();
        end
        chk("t40_stall_num", stall_num, 32'd1);
        chk("t40_grant_num", dbg_grant_num, 32'd2);
        // A fresh contested request must again take exactly MAX_WAIT cycles.
        dbg_req = 1; exp_q.push_back(ref_mem[11]);
        for (int c = 0; c < 5; c++) begin
            #1 chk($sformatf("t40_regnt_c%0d", c), {31'd0, dbg_gnt}, {31'd0, c == 4});
            if (c == 4) dbg_req = 0;
            cyc();
        end
        chk("t40_stall_num2", stall_num, 32'd2);
        chk("t40_grant_num2", dbg_grant_num, 32'd3);

        // Idle CPU with debug held: grants alternate.
        cpu_req = 0; dbg_req = 1; dbg_addr = 10'd9;
        for (int i = 0; i < 5; i++) exp_q.push_back(ref_mem[9]);
        for (int c = 0; c < 10; c++) begin
            #1 chk($sformatf("t42_gnt_c%0d", c), {31'd0, dbg_gnt}, {31'd0, c % 2 == 1});
            cyc();
        end
        dbg_req = 0;
        #1 chk("t42_grant_num", dbg_grant_num, 32'd8);
        chk("t42_stall_num", stall_num, 32'd2);
        cyc();
        cyc();

        // Reset in the middle of a grant.
        dbg_req = 1; dbg_addr = 10'd5;
        cyc();
        cpu_req = 1;
        #1 chk("t41_gnt_before", {31'd0, dbg_gnt}, 32'd1);
        chk("t41_stall_before", {31'd0, cpu_stall}, 32'd1);
        #1 rst = 1'b0;
        #1 chk("t41_gnt_async", {31'd0, dbg_gnt}, 32'd0);
        chk("t41_stall_async", {31'd0, cpu_stall}, 32'd0);
        chk("t41_grant_num", dbg_grant_num, 32'd0);
        chk("t41_stall_num", stall_num, 32'd0);
        dbg_req = 0;
        cyc();
        rst = 1'b1;
        cyc();
        #1 chk("t41_no_valid", {31'd0, dbg_valid}, 32'd0);
        chk("t41_cpu_owns", {31'd0, cpu_stall}, 32'd0);
        chk("t41_ram_addr", {22'd0, ram_addr}, {22'd0, cpu_addr});
        cpu_req = 0;
        cyc();
        cyc();
        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
